alexander_pd_voter: RTL and testbench

Bang-bang (Alexander) phase detector back end for the CDR. It produces the Up/Dn stream consumed by the digital loop filter.
- Each clk it receives one data sample and one edge sample from the slicers.
- Each UI is classified as early, late, none or invalid.
- Decisions are majority-voted over a window of VOTE_LEN UIs, and one-cycle Up or Dn pulses are emitted.
- Saturating transition and error statistics are also maintained.

---
 rtl/cdr_pkg.sv | 20 ++
 rtl/alexander_pd_classify.sv | 50 +++++
 rtl/alexander_pd_voter.sv | 95 +++++++++
 tb/tb_alexander_pd_voter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cdr_pkg.sv
// Shared CDR types: phase detector classes,
// vote encoding and accumulator sizing.
package cdr_pkg;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    EARLY   = 2'd1,
    LATE    = 2'd2,
    INVALID = 2'd3
  } pd_class_t;

  localparam logic signed [1:0] VOTE_NONE  = 2'sd0;
  localparam logic signed [1:0] VOTE_EARLY = -2'sd1;
  localparam logic signed [1:0] VOTE_LATE  = 2'sd1;

  function automatic int vote_w(input int n);
    return $clog2(n) + 2;
  endfunction

endpackage

// File: rtl/alexander_pd_classify.sv
// Alexander PD front: sample registers and
// per-UI early/late/invalid classification.
module alexander_pd_classify
  import cdr_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      en,
  input  logic      data_s,
  input  logic      edge_s,
  output pd_class_t cls,
  output logic      cls_vld
);

  logic a_q, b_q, t_q;
  logic a_vld, b_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= 1'b0;
      b_q   <= 1'b0;
      t_q   <= 1'b0;
      a_vld <= 1'b0;
      b_vld <= 1'b0;
    end else if (en) begin
      a_q   <= b_q;
      b_q   <= data_s;
      t_q   <= edge_s;
      b_vld <= 1'b1;
      a_vld <= b_vld;
    end else begin
      a_vld <= 1'b0;
      b_vld <= 1'b0;
    end
  end

  // A==B with a differing edge is a glitch
  always_comb begin
    cls = NONE;
    unique case (1'b1)
      (a_q == b_q) && (t_q != a_q): cls = INVALID;
      (a_q != b_q) && (t_q == a_q): cls = EARLY;
      (a_q != b_q) && (t_q == b_q): cls = LATE;
      default:                      cls = NONE;
    endcase
  end

  assign cls_vld = a_vld;

endmodule

// File: rtl/alexander_pd_voter.sv
// Bang-bang PD back end: majority vote window,
// Up/Dn pulse generation and saturating stats.
module alexander_pd_voter
  import cdr_pkg::*;
#(
  parameter int VOTE_LEN = 4,
  parameter int THRESH   = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             data_s,
  input  logic             edge_s,
  input  logic             clr_cnt,
  output logic             Up,
  output logic             Dn,
  output logic [CNT_W-1:0] trans_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int AW = vote_w(VOTE_LEN);
  localparam int WW = $clog2(VOTE_LEN) + 1;
  localparam logic signed [AW-1:0] THR = AW'(THRESH);
  localparam logic [WW-1:0] LAST = WW'(VOTE_LEN - 1);

  pd_class_t cls;
  logic      cls_vld;

  alexander_pd_classify u_cls (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .data_s  (data_s),
    .edge_s  (edge_s),
    .cls     (cls),
    .cls_vld (cls_vld)
  );

  logic signed [AW-1:0] acc, vote, fin;
  logic [WW-1:0]        win;
  logic                 is_tr, is_err;

  always_comb begin
    vote = AW'(VOTE_NONE);
    unique case (cls)
      EARLY:   vote = AW'(VOTE_EARLY);
      LATE:    vote = AW'(VOTE_LATE);
      default: vote = AW'(VOTE_NONE);
    endcase
  end

  assign fin    = acc + vote;
  assign is_tr  = cls_vld && (cls == EARLY || cls == LATE);
  assign is_err = cls_vld && (cls == INVALID);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      win <= '0;
      Up  <= 1'b0;
      Dn  <= 1'b0;
    end else begin
      Up <= 1'b0;
      Dn <= 1'b0;
      if (cls_vld) begin
        if (win == LAST) begin
          acc <= '0;
          win <= '0;
          Up  <= fin > THR;
          Dn  <= fin < -THR;
        end else begin
          acc <= fin;
          win <= win + WW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trans_cnt <= '0;
      err_cnt   <= '0;
    end else if (clr_cnt) begin
      trans_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (is_tr && trans_cnt != '1)
        trans_cnt <= trans_cnt + CNT_W'(1);
      if (is_err && err_cnt != '1)
        err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alexander_pd_voter.sv
// Directed bench for alexander_pd_voter: main,
// narrow-counter and no-decimation instances.
module tb_alexander_pd_voter;

  logic clk = 1'b0;
  logic rst_n, en, data_s, edge_s, clr_cnt;

  logic        up0, dn0, up1, dn1, up2, dn2;
  logic [15:0] tr0, er0, tr2, er2;
  logic [3:0]  tr1, er1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alexander_pd_voter #(.VOTE_LEN(4), .THRESH(0), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .data_s(data_s),
    .edge_s(edge_s), .clr_cnt(clr_cnt), .Up(up0), .Dn(dn0),
    .trans_cnt(tr0), .err_cnt(er0)
  );

  alexander_pd_voter #(.VOTE_LEN(4), .THRESH(0), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .data_s(data_s),
    .edge_s(edge_s), .clr_cnt(clr_cnt), .Up(up1), .Dn(dn1),
    .trans_cnt(tr1), .err_cnt(er1)
  );

  alexander_pd_voter #(.VOTE_LEN(1), .THRESH(0), .CNT_W(16)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .data_s(data_s),
    .edge_s(edge_s), .clr_cnt(clr_cnt), .Up(up2), .Dn(dn2),
    .trans_cnt(tr2), .err_cnt(er2)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic e, input logic d, input logic t);
    en = e;
    data_s = d;
    edge_s = t;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; data_s = 1'b0;
    edge_s = 1'b0; clr_cnt = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_up", up0, 0);
    chk("rst_dn", dn0, 0);
    chk("rst_tr", tr0, 0);
    chk("rst_er", er0, 0);
    rst_n = 1'b1;
    idle();

    // four LATE UIs after one dropped UI
    step(1, 0, 0);
    step(1, 1, 1);
    chk("byp_nothing_yet", up2, 0);
    step(1, 0, 0);
    chk("byp_late_up", up2, 1);
    chk("late_no_early_up", up0, 0);
    step(1, 1, 1);
    step(1, 0, 0);
    chk("late_pre_up", up0, 0);
    idle();
    chk("late_up", up0, 1);
    chk("late_dn", dn0, 0);
    chk("late_tr", tr0, 4);
    chk("byp_late_tr", tr2, 4);
    idle();
    chk("late_up_1cyc", up0, 0);

    // E L E L balanced
    step(1, 0, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    chk("byp_early_dn", dn2, 1);
    chk("byp_early_up", up2, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    idle();
    chk("bal_up", up0, 0);
    chk("bal_dn", dn0, 0);
    chk("bal_tr", tr0, 8);

    // three EARLY plus one NONE
    step(1, 0, 0);
    step(1, 1, 0);
    step(1, 0, 1);
    step(1, 1, 0);
    step(1, 1, 1);
    idle();
    chk("early_dn", dn0, 1);
    chk("early_up", up0, 0);
    chk("early_tr", tr0, 11);
    chk("byp_none_up", up2, 0);
    chk("byp_none_dn", dn2, 0);
    idle();
    chk("early_dn_1cyc", dn0, 0);

    // invalid 010 then 101 x2
    step(1, 0, 0);
    step(1, 0, 1);
    idle();
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    idle();
    chk("inv_err", er0, 3);
    chk("inv_tr", tr0, 11);
    chk("inv_up", up0, 0);
    chk("inv_dn", dn0, 0);

    // clear wins over a same-cycle invalid UI
    step(1, 1, 0);
    step(1, 1, 0);
    clr_cnt = 1'b1;
    idle();
    clr_cnt = 1'b0;
    chk("clr_err", er0, 0);
    chk("clr_tr", tr0, 0);
    chk("clr_win_up", up0, 0);

    // enable gap inside a window
    step(1, 0, 0);
    step(1, 1, 1);
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      idle();
      chk("gap_up", up0, 0);
    end
    step(1, 1, 1);
    step(1, 0, 0);
    step(1, 1, 1);
    chk("gap_pre_up", up0, 0);
    idle();
    chk("gap_up_end", up0, 1);
    chk("gap_tr", tr0, 4);

    // async reset while Up is high
    #2 rst_n = 1'b0;
    #1;
    chk("arst_up", up0, 0);
    chk("arst_tr", tr0, 0);
    chk("arst_er", er0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // reset discards a partial window
    step(1, 0, 0);
    step(1, 1, 1);
    step(1, 0, 0);
    step(1, 1, 1);
    idle();
    chk("part_up", up0, 0);
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1, 0, 0);
    step(1, 1, 1);
    idle();
    chk("part_discard_up", up0, 0);
    chk("part_tr", tr0, 1);

    // 20 more LATE UIs saturate the 4-bit counter
    step(1, 0, 0);
    for (int i = 1; i <= 20; i++)
      step(1, 1'(i % 2), 1'(i % 2));
    idle();
    chk("sat_tr1", tr1, 15);
    chk("sat_tr0", tr0, 21);
    step(1, 0, 0);
    step(1, 1, 1);
    step(1, 0, 0);
    idle();
    chk("sat_hold", tr1, 15);
    chk("sat_tr0_more", tr0, 23);
    chk("sat_err", er0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
